// File: rtl/deque_arb_pkg.sv
// Shared types for the deque access arbiter: op codes and response payload.
package deque_arb_pkg;

    localparam int unsigned DQ_NREQ   = 4;
    localparam int unsigned DQ_ID_W   = $clog2(DQ_NREQ);
    localparam int unsigned DQ_DATA_W = 32;

    // Deque operation codes; encodings 5-7 are illegal and answered with an error.
    typedef enum logic [2:0] {
        DQ_PUSH_BACK  = 3'd0,
        DQ_PUSH_FRONT = 3'd1,
        DQ_POP_FRONT  = 3'd2,
        DQ_POP_BACK   = 3'd3,
        DQ_CLEAR      = 3'd4
    } dq_op_e;

    // Response payload as seen by a requester.
    typedef struct packed {
        logic                 valid;
        logic [DQ_ID_W-1:0]   id;
        logic [DQ_DATA_W-1:0] data;
        logic                 err;
    } dq_rsp_s;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the last winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Search the request vector starting one past the last winner, wrapping.
    always_comb begin
        int unsigned cand;
        logic        found;
        logic [IDX_W-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    // Pointer only moves when a grant is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && (|grant)) begin
            rr_ptr_d = grant_idx;
        end
    end

    // Pointer register; reset makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= IDX_W'(N - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/deque_access_arbiter.sv
// Deque access arbiter: NREQ requesters share one circular-buffer deque.
// One op per cycle is granted round-robin; each grant yields one registered
// response one cycle later. Optional statistics outputs: DQ_ARB_STATS_EN.
module deque_access_arbiter
    import deque_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_h,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0][2:0]          req_op,
    input  logic [NREQ-1:0][WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [WIDTH-1:0]              rsp_data,
    output logic                          rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
`ifdef DQ_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_ops,
    output logic [31:0]                   stat_err,
    output logic [$clog2(DEPTH+1)-1:0]    stat_hiwater
`endif
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;

    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_idx;
    logic             hs;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_data;

    logic [PTR_W-1:0] head_p1, head_m1, tail_p1, tail_m1;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst_h),
        .req      (req_valid),
        .advance  (hs),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    assign req_ready = grant;
    // Ready is a grant on a valid line, so any valid request completes a handshake.
    assign hs        = |req_valid;
    assign sel_op    = req_op[grant_idx];
    assign sel_data  = req_data[grant_idx];

    // Neighbouring pointer values with explicit wrap at the buffer ends.
    always_comb begin
        head_p1 = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
        head_m1 = (head_q == '0) ? PTR_W'(DEPTH - 1) : head_q - PTR_W'(1);
        tail_p1 = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        tail_m1 = (tail_q == '0) ? PTR_W'(DEPTH - 1) : tail_q - PTR_W'(1);
    end

    // Decode the granted op into pointer/count updates, storage write and response.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        mem_we      = 1'b0;
        mem_waddr   = tail_q;
        mem_wdata   = sel_data;
        rsp_valid_d = hs;
        rsp_id_d    = hs ? grant_idx : '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        if (hs) begin
            case (sel_op)
                DQ_PUSH_BACK: begin
                    if (full_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = tail_q;
                        tail_d    = tail_p1;
                        count_d   = count_q + CNT_W'(1);
                    end
                end
                DQ_PUSH_FRONT: begin
                    if (full_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = head_m1;
                        head_d    = head_m1;
                        count_d   = count_q + CNT_W'(1);
                    end
                end
                DQ_POP_FRONT: begin
                    if (empty_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = mem[head_q];
                        head_d     = head_p1;
                        count_d    = count_q - CNT_W'(1);
                    end
                end
                DQ_POP_BACK: begin
                    if (empty_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = mem[tail_m1];
                        tail_d     = tail_m1;
                        count_d    = count_q - CNT_W'(1);
                    end
                end
                DQ_CLEAR: begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end
                default: begin
                    rsp_err_d = 1'b1;
                end
            endcase
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Deque state, status flags and response register.
    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(DEPTH));
            empty_q     <= (count_d == '0);
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

`ifdef DQ_ARB_STATS_EN
    logic [31:0]      stat_ops_q, stat_err_q;
    logic [CNT_W-1:0] stat_hiwater_q;

    // Saturating op/error counters and occupancy high-water mark; CLEAR does not touch them.
    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            stat_ops_q     <= '0;
            stat_err_q     <= '0;
            stat_hiwater_q <= '0;
        end else begin
            if (hs && (stat_ops_q != '1)) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if (rsp_err_d && (stat_err_q != '1)) begin
                stat_err_q <= stat_err_q + 32'd1;
            end
            if (count_d > stat_hiwater_q) begin
                stat_hiwater_q <= count_d;
            end
        end
    end

    assign stat_ops     = stat_ops_q;
    assign stat_err     = stat_err_q;
    assign stat_hiwater = stat_hiwater_q;
`endif

endmodule
